// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 serial link: register addresses, frame
// width and the receiver state encoding.
package max7219_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  typedef enum logic [1:0] {
    RX_WAIT_IDLE = 2'd0,
    RX_IDLE      = 2'd1,
    RX_SHIFT     = 2'd2
  } rx_state_e;

endpackage

// File: rtl/max7219_receiver_sync.sv
// sync_edge_detect: SYNC_STAGES-deep synchronizer with single-cycle rise/fall
// pulses derived from the synchronized level.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/max7219_receiver.sv
// MAX7219-compatible serial receiver: decodes DIN/CS/SCLK frames into the
// register map. Optional daisy-chain DOUT enabled by MAX7219_DAISY_OUT_EN.
module max7219_receiver
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ROWS        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       cs,
  input  logic       sclk,
  input  logic [2:0] row_sel,
  output logic [7:0] row_data,
  output logic [7:0] decode_mode,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic       shutdown_n,
  output logic       display_test,
  output logic       frame_valid,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_err,
  output logic       dout
);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s_unused, sclk_rise, sclk_fall;
  logic din_s, din_rise_unused, din_fall_unused;

  // CS idles high, so its synchronizer resets to 1 to avoid a false fall.
  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .async_in(cs),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_in(sclk),
    .level(sclk_s_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
    .clk(clk), .rst_n(rst_n), .async_in(din),
    .level(din_s), .rise(din_rise_unused), .fall(din_fall_unused)
  );

  rx_state_e   state;
  logic [15:0] shift_q;
  logic [4:0]  bit_cnt;
  logic [7:0]  rows [ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RX_WAIT_IDLE;
      shift_q      <= '0;
      bit_cnt      <= '0;
      for (int i = 0; i < ROWS; i++) rows[i] <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
      frame_valid  <= 1'b0;
      frame_err    <= 1'b0;
      frame_addr   <= '0;
      frame_data   <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        RX_WAIT_IDLE: if (cs_s) state <= RX_IDLE;
        RX_IDLE: begin
          if (cs_fall) begin
            shift_q <= '0;
            bit_cnt <= '0;
            state   <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          // A CS rise in the same cycle as an SCLK rise drops that bit.
          if (cs_rise) begin
            state <= RX_IDLE;
            if (bit_cnt >= 5'(FRAME_BITS)) begin
              frame_valid <= 1'b1;
              frame_addr  <= shift_q[11:8];
              frame_data  <= shift_q[7:0];
              case (shift_q[11:8])
                ADDR_DECODE:    decode_mode  <= shift_q[7:0];
                ADDR_INTENSITY: intensity    <= shift_q[3:0];
                ADDR_SCANLIMIT: scan_limit   <= shift_q[2:0];
                ADDR_SHUTDOWN:  shutdown_n   <= shift_q[0];
                ADDR_TEST:      display_test <= shift_q[0];
                default: begin
                  for (int i = 0; i < ROWS; i++)
                    if (shift_q[11:8] == 4'(i + 1)) rows[i] <= shift_q[7:0];
                end
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            shift_q <= {shift_q[14:0], din_s};
            if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: state <= RX_WAIT_IDLE;
      endcase
    end
  end

  always_comb begin
    row_data = '0;
    for (int i = 0; i < ROWS; i++)
      if (int'(row_sel) == i) row_data = rows[i];
  end

`ifdef MAX7219_DAISY_OUT_EN
  // The bit leaving the top of the shift register appears 16 SCLKs later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 dout <= 1'b0;
    else if (state != RX_SHIFT) dout <= 1'b0;
    else if (sclk_fall)         dout <= shift_q[15];
  end
`else
  logic sclk_fall_unused;
  assign sclk_fall_unused = sclk_fall;
  assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_max7219_receiver.sv
// Self-checking bench for max7219_receiver: randomized frames against a
// register-map reference model plus directed boundary scenarios.
module tb_max7219_receiver;
  import max7219_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       cs = 1'b1;
  logic       sclk = 1'b0;
  logic [2:0] row_sel = '0;
  logic [7:0] row_data, decode_mode, frame_data;
  logic [3:0] intensity, frame_addr;
  logic [2:0] scan_limit;
  logic       shutdown_n, display_test, frame_valid, frame_err, dout;

  max7219_receiver #(.SYNC_STAGES(2), .ROWS(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .cs(cs), .sclk(sclk),
    .row_sel(row_sel), .row_data(row_data), .decode_mode(decode_mode),
    .intensity(intensity), .scan_limit(scan_limit), .shutdown_n(shutdown_n),
    .display_test(display_test), .frame_valid(frame_valid),
    .frame_addr(frame_addr), .frame_data(frame_data), .frame_err(frame_err),
    .dout(dout)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  // reference model of the register map
  logic [7:0]  m_rows [8];
  logic [7:0]  m_decode;
  logic [3:0]  m_int;
  logic [2:0]  m_scan;
  logic        m_shut, m_test;
  logic [11:0] exp_q[$];
  logic [11:0] sb_exp;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
    m_decode = 8'h00; m_int = 4'h0; m_scan = 3'h0; m_shut = 1'b0; m_test = 1'b0;
  endtask

  task automatic model_apply(input logic [15:0] f);
    int a;
    a = int'(f[11:8]);
    exp_q.push_back(f[11:0]);
    if (a >= 1 && a <= 8) m_rows[a-1] = f[7:0];
    else if (a == 9)  m_decode = f[7:0];
    else if (a == 10) m_int = f[3:0];
    else if (a == 11) m_scan = f[2:0];
    else if (a == 12) m_shut = f[0];
    else if (a == 15) m_test = f[0];
  endtask

  // scoreboard: every accepted frame must match the next expected frame
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_cnt++;
      if (frame_valid) begin
        valid_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got %h, required no frame", {frame_addr, frame_data});
        end else begin
          sb_exp = exp_q.pop_front();
          if ({frame_addr, frame_data} !== sb_exp) begin
            bad++;
            $display("FAIL sb_frame: got %h, required %h", {frame_addr, frame_data}, sb_exp);
          end
        end
      end
    end
  end

  // driver: n bits of 'bits' MSB first, SCLK half period 'half' clk cycles
  task automatic send_bits(input logic [31:0] bits, input int n, input int half,
                           output int lat, output logic [31:0] dsamp);
    dsamp = '0;
    lat = -1;
    @(negedge clk);
    cs = 1'b0; sclk = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      din = bits[n-1-i];
      sclk = 1'b0;
      repeat (half) @(negedge clk);
      dsamp[31-i] = dout;
      sclk = 1'b1;
      repeat (half) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (half) @(negedge clk);
    if (n >= 16) model_apply(bits[15:0]);
    cs = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (lat < 0 && (frame_valid || frame_err)) lat = k;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    total++;
    if ({decode_mode, intensity, scan_limit, shutdown_n, display_test, frame_valid,
         frame_addr, frame_data, frame_err, dout} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h, required 0", {decode_mode, intensity, scan_limit,
               shutdown_n, display_test, frame_valid, frame_addr, frame_data, frame_err, dout});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int r = 0; r < 8; r++) begin
      row_sel = 3'(r);
      #1;
      total++;
      if (row_data !== 8'h00) begin
        bad++;
        $display("FAIL reset_row%0d: got %h, required 00", r, row_data);
      end
    end
  endtask

  task automatic test_shutdown();
    int v0, lat;
    logic [31:0] ds;
    v0 = valid_cnt;
    send_bits(32'h0C01, 16, 4, lat, ds);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL shut_latency: got %0d, required 3", lat); end
    total++;
    if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL shut_valid_cnt: got %0d, required 1", valid_cnt - v0); end
    total++;
    if ({frame_addr, frame_data, shutdown_n} !== {4'hC, 8'h01, 1'b1}) begin
      bad++;
      $display("FAIL shut_regs: got %h/%h/%b, required c/01/1", frame_addr, frame_data, shutdown_n);
    end
    for (int r = 0; r < 8; r++) begin
      row_sel = 3'(r);
      #1;
      total++;
      if (row_data !== 8'h00) begin bad++; $display("FAIL shut_row%0d: got %h, required 00", r, row_data); end
    end
  endtask

  task automatic test_rows();
    int lat;
    logic [31:0] ds;
    logic [2:0] sel [3];
    logic [7:0] req [3];
    sel[0] = 3'd0; req[0] = 8'h18;
    sel[1] = 3'd7; req[1] = 8'hFF;
    sel[2] = 3'd3; req[2] = 8'h00;
    send_bits(32'h0118, 16, 4, lat, ds);
    send_bits(32'h08FF, 16, 4, lat, ds);
    for (int i = 0; i < 3; i++) begin
      row_sel = sel[i];
      #1;
      total++;
      if (row_data !== req[i]) begin
        bad++;
        $display("FAIL rows_sel%0d: got %h, required %h", sel[i], row_data, req[i]);
      end
    end
  endtask

  task automatic test_long_burst();
    int v0, e0, lat;
    logic [31:0] ds;
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(32'h000A0A05, 20, 4, lat, ds);
    total++;
    if (intensity !== 4'h5) begin bad++; $display("FAIL burst_intensity: got %h, required 5", intensity); end
    total++;
    if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
      bad++;
      $display("FAIL burst_pulses: got valid=%0d err=%0d, required valid=1 err=0", valid_cnt - v0, err_cnt - e0);
    end
  endtask

  task automatic test_short();
    int v0, e0, lat;
    logic [31:0] ds;
    logic [22:0] snap;
    v0 = valid_cnt; e0 = err_cnt;
    snap = {decode_mode, intensity, scan_limit, shutdown_n, display_test, frame_addr, frame_data[1:0]};
    send_bits(32'h02AB, 10, 4, lat, ds);
    total++;
    if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
      bad++;
      $display("FAIL short_pulses: got err=%0d valid=%0d, required err=1 valid=0", err_cnt - e0, valid_cnt - v0);
    end
    total++;
    if (lat !== 3) begin bad++; $display("FAIL short_latency: got %0d, required 3", lat); end
    total++;
    if ({decode_mode, intensity, scan_limit, shutdown_n, display_test, frame_addr, frame_data[1:0]} !== snap) begin
      bad++;
      $display("FAIL short_regs: got %h, required %h", {decode_mode, intensity, scan_limit,
               shutdown_n, display_test, frame_addr, frame_data[1:0]}, snap);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, lat;
    logic [31:0] ds;
    logic [15:0] f;
    f = 16'h0B07;
    v0 = valid_cnt;
    @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = f[15-i]; sclk = 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    if (valid_cnt - v0 !== 0) begin bad++; $display("FAIL rstmid_valid: got %0d, required 0", valid_cnt - v0); end
    total++;
    if ({scan_limit, shutdown_n} !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_regs: got scan=%0d shut=%b, required 0/0", scan_limit, shutdown_n);
    end
    send_bits(32'h0B07, 16, 4, lat, ds);
    total++;
    if (scan_limit !== 3'd7) begin bad++; $display("FAIL rstmid_refill: got %0d, required 7", scan_limit); end
  endtask

  task automatic test_random();
    int lat, n, half;
    logic [31:0] bits, ds;
    for (int it = 0; it < 24; it++) begin
      bits = $urandom;
      n = $urandom_range(16, 24);
      half = $urandom_range(2, 5);
      send_bits(bits, n, half, lat, ds);
      total++;
      if (lat !== 3) begin bad++; $display("FAIL rand%0d_latency: got %0d, required 3", it, lat); end
      total++;
      if ({decode_mode, intensity, scan_limit, shutdown_n, display_test} !== {m_decode, m_int, m_scan, m_shut, m_test}) begin
        bad++;
        $display("FAIL rand%0d_ctrl: got %h, required %h", it,
                 {decode_mode, intensity, scan_limit, shutdown_n, display_test}, {m_decode, m_int, m_scan, m_shut, m_test});
      end
      row_sel = 3'($urandom_range(0, 7));
      #1;
      total++;
      if (row_data !== m_rows[row_sel]) begin
        bad++;
        $display("FAIL rand%0d_row%0d: got %h, required %h", it, row_sel, row_data, m_rows[row_sel]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int v0, lat;
    logic [31:0] ds;
    v0 = valid_cnt;
    for (int r = 0; r < 4; r++) send_bits({16'h0, 4'h0, 4'(r + 1), 8'(8'h40 + r)}, 16, 2, lat, ds);
    total++;
    if (valid_cnt - v0 !== 4) begin bad++; $display("FAIL b2b_count: got %0d, required 4", valid_cnt - v0); end
    for (int r = 0; r < 4; r++) begin
      row_sel = 3'(r);
      #1;
      total++;
      if (row_data !== 8'(8'h40 + r)) begin
        bad++;
        $display("FAIL b2b_row%0d: got %h, required %h", r, row_data, 8'(8'h40 + r));
      end
    end
  endtask

  task automatic test_daisy();
    int lat;
    logic [31:0] ds;
    send_bits(32'h0F00, 16, 4, lat, ds);
    send_bits(32'h0F010000, 32, 4, lat, ds);
    total++;
    if (display_test !== 1'b0) begin bad++; $display("FAIL daisy_test_reg: got %b, required 0", display_test); end
`ifdef MAX7219_DAISY_OUT_EN
    total++;
    if (ds !== 32'h00000F01) begin bad++; $display("FAIL daisy_dout: got %h, required 00000f01", ds); end
`else
    total++;
    if (ds !== 32'h0) begin bad++; $display("FAIL daisy_dout: got %h, required 0", ds); end
`endif
  endtask

  initial begin
    test_reset();
    test_shutdown();
    test_rows();
    test_long_burst();
    test_short();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    test_daisy();
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
